// File: rtl/host_bridge_pkg.sv
// Shared types for the host command bridge: command record, sequencer states, bus widths.
package host_bridge_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } host_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RSP   = 2'd2
  } state_t;

endpackage

// File: rtl/host_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit so full/empty/level
// come straight from registered pointers, and ready is itself a register.
module host_cmd_fifo
  import host_bridge_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        srst,
  input  logic                        push,
  input  host_cmd_t                   push_data,
  input  logic                        pop,
  output host_cmd_t                   pop_data,
  output logic                        ready,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  host_cmd_t        mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   wr_ptr_next, rd_ptr_next, level_next;
  logic             ready_reg;
  logic             push_ok, pop_ok;

  assign push_ok     = push & ready_reg;
  assign pop_ok      = pop & !empty;
  assign wr_ptr_next = wr_ptr_reg + {{PTR_W{1'b0}}, push_ok};
  assign rd_ptr_next = rd_ptr_reg + {{PTR_W{1'b0}}, pop_ok};
  assign level_next  = wr_ptr_next - rd_ptr_next;

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      ready_reg  <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      ready_reg  <= (level_next != (PTR_W+1)'(FIFO_DEPTH));
    end
  end

  // Storage is not reset: a flush only needs the pointers cleared.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr_reg[PTR_W-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr_reg[PTR_W-1:0]];
  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign level    = wr_ptr_reg - rd_ptr_reg;
  assign ready    = ready_reg;

endmodule

// File: rtl/host_cmd_bridge.sv
// Command FIFO + in-order host transaction sequencer with read-response stream.
// Optional per-direction transaction counters enabled by HOST_CMD_BRIDGE_STATS_EN.
module host_cmd_bridge
  import host_bridge_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        host_clk_i,
  input  logic                        reset_i,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic                        cmd_wr_i,
  input  logic [ADDR_W-1:0]           cmd_addr_i,
  input  logic [DATA_W-1:0]           cmd_wdata_i,
  output logic                        host_sel_o,
  output logic                        host_wr_o,
  output logic [ADDR_W-1:0]           host_addr_o,
  output logic [DATA_W-1:0]           host_wdata_o,
  input  logic [DATA_W-1:0]           host_rdata_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [DATA_W-1:0]           rsp_rdata_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic [15:0]                 wr_count_o,
  output logic [15:0]                 rd_count_o
);

  host_cmd_t         fifo_in, fifo_head;
  logic              fifo_pop, fifo_empty;

  state_t            state_reg, state_next;
  host_cmd_t         host_reg, host_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic              try_pop;

  assign fifo_in = '{wr: cmd_wr_i, addr: cmd_addr_i, wdata: cmd_wdata_i};

  host_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (host_clk_i),
    .srst      (reset_i),
    .push      (cmd_valid_i),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .ready     (cmd_ready_o),
    .empty     (fifo_empty),
    .level     (fifo_level_o)
  );

  always_comb begin
    state_next     = state_reg;
    host_next      = host_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_rdata_next = rsp_rdata_reg;
    fifo_pop       = 1'b0;
    try_pop        = 1'b0;
    case (state_reg)
      IDLE:  try_pop = 1'b1;
      ISSUE: begin
        // A read parks the sequencer until its response is taken, keeping order strict.
        if (host_reg.wr) begin
          try_pop = 1'b1;
        end else begin
          rsp_valid_next = 1'b1;
          rsp_rdata_next = host_rdata_i;
          state_next     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_next = 1'b0;
          try_pop        = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (try_pop) begin
      state_next = IDLE;
      if (!fifo_empty) begin
        fifo_pop   = 1'b1;
        host_next  = fifo_head;
        state_next = ISSUE;
      end
    end
  end

  always_ff @(posedge host_clk_i) begin
    if (reset_i) begin
      state_reg     <= IDLE;
      host_reg      <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      host_reg      <= host_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
    end
  end

  assign host_sel_o   = (state_reg == ISSUE);
  assign host_wr_o    = host_reg.wr;
  assign host_addr_o  = host_reg.addr;
  assign host_wdata_o = host_reg.wdata;
  assign rsp_valid_o  = rsp_valid_reg;
  assign rsp_rdata_o  = rsp_rdata_reg;
  assign busy_o       = !fifo_empty | host_sel_o | rsp_valid_reg;

`ifdef HOST_CMD_BRIDGE_STATS_EN
  logic [15:0] wr_count_reg, rd_count_reg;

  always_ff @(posedge host_clk_i) begin
    if (reset_i) begin
      wr_count_reg <= '0;
      rd_count_reg <= '0;
    end else if (host_sel_o) begin
      if (host_wr_o && wr_count_reg != 16'hFFFF)
        wr_count_reg <= wr_count_reg + 16'd1;
      if (!host_wr_o && rd_count_reg != 16'hFFFF)
        rd_count_reg <= rd_count_reg + 16'd1;
    end
  end

  assign wr_count_o = wr_count_reg;
  assign rd_count_o = rd_count_reg;
`else
  assign wr_count_o = 16'd0;
  assign rd_count_o = 16'd0;
`endif

endmodule

// File: tb/tb_host_cmd_bridge.sv
// Self-checking bench for host_cmd_bridge: directed timing steps plus a random phase,
// with a scoreboard (command queue + memory model) checking every strobe and response.
module tb_host_cmd_bridge;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_wr_i = 1'b0;
  logic [3:0]  cmd_addr_i = 4'd0;
  logic [7:0]  cmd_wdata_i = 8'd0;
  logic        host_sel_o, host_wr_o;
  logic [3:0]  host_addr_o;
  logic [7:0]  host_wdata_o, host_rdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [7:0]  rsp_rdata_o;
  logic        busy_o;
  logic [2:0]  fifo_level_o;
  logic [15:0] wr_count_o, rd_count_o;

  host_cmd_bridge #(.FIFO_DEPTH(4)) dut (
    .host_clk_i   (clk),
    .reset_i      (reset_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_wr_i     (cmd_wr_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_wdata_i  (cmd_wdata_i),
    .host_sel_o   (host_sel_o),
    .host_wr_o    (host_wr_o),
    .host_addr_o  (host_addr_o),
    .host_wdata_o (host_wdata_o),
    .host_rdata_i (host_rdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .busy_o       (busy_o),
    .fifo_level_o (fifo_level_o),
    .wr_count_o   (wr_count_o),
    .rd_count_o   (rd_count_o)
  );

  always #5 clk = ~clk;

  // Host memory the DUT talks to, and the bench's own view of what it should hold.
  logic [7:0] host_mem [16];
  logic [7:0] model_mem [16];
  assign host_rdata_i = host_mem[host_addr_o];
  always @(posedge clk) if (host_sel_o && host_wr_o) host_mem[host_addr_o] <= host_wdata_o;

  typedef struct { logic wr; logic [3:0] addr; logic [7:0] wdata; } cmd_s;
  cmd_s       cmd_q[$];
  logic [7:0] rsp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         wr_seen = 0;
  int         rd_seen = 0;
  int         handshakes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: accepted commands must appear as strobes in order; reads return model data.
  always @(negedge clk) begin
    if (reset_i) begin
      cmd_q.delete();
      rsp_q.delete();
      wr_seen = 0;
      rd_seen = 0;
    end else begin
      if (cmd_valid_i && cmd_ready_o)
        cmd_q.push_back('{wr: cmd_wr_i, addr: cmd_addr_i, wdata: cmd_wdata_i});
      check("strobe_while_rsp", {31'd0, host_sel_o & rsp_valid_o}, 32'd0);
      if (host_sel_o) begin
        check("strobe_has_cmd", {31'd0, cmd_q.size() != 0}, 32'd1);
        if (cmd_q.size() != 0) begin
          cmd_s c;
          c = cmd_q.pop_front();
          $display("strobe wr=%0d addr=%0h wdata=%0h", host_wr_o, host_addr_o, host_wdata_o);
          check("strobe_wr", {31'd0, host_wr_o}, {31'd0, c.wr});
          check("strobe_addr", {28'd0, host_addr_o}, {28'd0, c.addr});
          if (c.wr) begin
            check("strobe_wdata", {24'd0, host_wdata_o}, {24'd0, c.wdata});
            model_mem[c.addr] = c.wdata;
            wr_seen++;
          end else begin
            rsp_q.push_back(model_mem[c.addr]);
            rd_seen++;
          end
        end
      end
      if (rsp_valid_o && rsp_ready_i) begin
        handshakes++;
        check("rsp_has_read", {31'd0, rsp_q.size() != 0}, 32'd1);
        if (rsp_q.size() != 0) begin
          logic [7:0] e;
          e = rsp_q.pop_front();
          $display("response rdata=%0h", rsp_rdata_o);
          check("rsp_rdata", {24'd0, rsp_rdata_o}, {24'd0, e});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [3:0] a, input logic [7:0] d);
    cmd_valid_i = v;
    cmd_wr_i    = w;
    cmd_addr_i  = a;
    cmd_wdata_i = d;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && busy_o; i++) tick();
    check(tag, {31'd0, busy_o}, 32'd0);
  endtask

  cmd_s       cmds [6];
  int         acc;
  int         k;
  int         hs0;
  logic [8:0] pat;
  logic [8:0] pat_exp;
  logic [15:0] exp_wr, exp_rd;

  initial begin
    for (int i = 0; i < 16; i++) begin
      host_mem[i]  = 8'($urandom);
      model_mem[i] = host_mem[i];
    end

    // Reset held three cycles: every output at its reset value.
    reset_i = 1'b1;
    repeat (3) tick();
    check("rst_ready", {31'd0, cmd_ready_o}, 32'd0);
    check("rst_sel", {31'd0, host_sel_o}, 32'd0);
    check("rst_host", {19'd0, host_wr_o, host_addr_o, host_wdata_o}, 32'd0);
    check("rst_rsp", {23'd0, rsp_valid_o, rsp_rdata_o}, 32'd0);
    check("rst_busy_level", {28'd0, busy_o, fifo_level_o}, 32'd0);
    check("rst_counts", {wr_count_o, rd_count_o}, 32'd0);
    reset_i = 1'b0;
    tick();
    check("rel_ready", {31'd0, cmd_ready_o}, 32'd1);
    check("rel_level", {29'd0, fifo_level_o}, 32'd0);

    // Back-to-back writes: strobes in consecutive cycles, two cycles after acceptance.
    rsp_ready_i = 1'b1;
    drive(1'b1, 1'b1, 4'd3, 8'hA5);
    tick();
    drive(1'b1, 1'b1, 4'd4, 8'h5A);
    tick();
    drive(1'b0, 1'b0, 4'd0, 8'd0);
    check("b2b_sel0", {31'd0, host_sel_o}, 32'd1);
    check("b2b_cmd0", {19'd0, host_wr_o, host_addr_o, host_wdata_o}, {19'd0, 1'b1, 4'd3, 8'hA5});
    tick();
    check("b2b_sel1", {31'd0, host_sel_o}, 32'd1);
    check("b2b_cmd1", {19'd0, host_wr_o, host_addr_o, host_wdata_o}, {19'd0, 1'b1, 4'd4, 8'h5A});
    tick();
    check("b2b_after", {30'd0, host_sel_o, busy_o}, 32'd0);

    // Read behind a write with the consumer stalled for five cycles.
    rsp_ready_i = 1'b0;
    drive(1'b1, 1'b1, 4'd7, 8'h3C);
    tick();
    drive(1'b1, 1'b0, 4'd7, 8'h00);
    tick();
    drive(1'b0, 1'b0, 4'd0, 8'd0);
    tick();
    check("rd_sel", {30'd0, host_sel_o, host_wr_o}, 32'd2);
    tick();
    hs0 = handshakes;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'd0, rsp_valid_o}, 32'd1);
      check("stall_data", {24'd0, rsp_rdata_o}, 32'h3C);
      check("stall_nosel", {31'd0, host_sel_o}, 32'd0);
      tick();
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check("one_handshake", handshakes - hs0, 32'd1);
    check("rsp_dropped", {31'd0, rsp_valid_o}, 32'd0);

    // Fill the FIFO behind a stalled read response.
    drive(1'b1, 1'b0, 4'($urandom), 8'd0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 8'd0);
    for (int i = 0; i < 20 && !rsp_valid_o; i++) tick();
    check("full_rsp_wait", {31'd0, rsp_valid_o}, 32'd1);
    for (int i = 0; i < 6; i++)
      cmds[i] = '{wr: 1'($urandom), addr: 4'($urandom), wdata: 8'($urandom)};
    acc = 0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, cmds[k].wr, cmds[k].addr, cmds[k].wdata);
      if (cmd_ready_o) begin
        acc++;
        k++;
      end
      tick();
    end
    drive(1'b0, 1'b0, 4'd0, 8'd0);
    check("full_accepted", acc, 32'd4);
    check("full_level", {29'd0, fifo_level_o}, 32'd4);
    check("full_ready", {31'd0, cmd_ready_o}, 32'd0);
    rsp_ready_i = 1'b1;
    wait_idle("full_drain", 60);
    check("full_queues", cmd_q.size() + rsp_q.size(), 32'd0);

    // Reset with three entries queued and a response pending.
    rsp_ready_i = 1'b0;
    drive(1'b1, 1'b0, 4'($urandom), 8'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 4'($urandom), 8'($urandom));
      tick();
    end
    drive(1'b0, 1'b0, 4'd0, 8'd0);
    check("pre_rst_state", {28'd0, rsp_valid_o, fifo_level_o}, {28'd0, 1'b1, 3'd3});
    reset_i = 1'b1;
    tick();
    check("mid_rst_level", {29'd0, fifo_level_o}, 32'd0);
    check("mid_rst_rsp", {30'd0, rsp_valid_o, host_sel_o}, 32'd0);
    reset_i = 1'b0;
    tick();
    check("post_rst_ready", {31'd0, cmd_ready_o}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("post_rst_nosel", {31'd0, host_sel_o}, 32'd0);
      tick();
    end

    // Two writes then three reads with the consumer always ready: strobe pattern and stats.
    rsp_ready_i = 1'b1;
    pat = '0;
    for (int j = 0; j < 12; j++) begin
      if (j < 2)      drive(1'b1, 1'b1, 4'($urandom), 8'($urandom));
      else if (j < 5) drive(1'b1, 1'b0, 4'($urandom), 8'd0);
      else            drive(1'b0, 1'b0, 4'd0, 8'd0);
      tick();
      if (j >= 1 && j <= 9) pat[9-j] = host_sel_o;
    end
    pat_exp = 9'b111010100;
    check("sel_pattern", {23'd0, pat}, {23'd0, pat_exp});
    wait_idle("stats_drain", 20);
`ifdef HOST_CMD_BRIDGE_STATS_EN
    exp_wr = 16'd2;
    exp_rd = 16'd3;
`else
    exp_wr = 16'd0;
    exp_rd = 16'd0;
`endif
    check("stats_wr", {16'd0, wr_count_o}, {16'd0, exp_wr});
    check("stats_rd", {16'd0, rd_count_o}, {16'd0, exp_rd});

    // Random traffic with random backpressure, checked by the scoreboard.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom));
      rsp_ready_i = 1'($urandom);
      tick();
    end
    drive(1'b0, 1'b0, 4'd0, 8'd0);
    rsp_ready_i = 1'b1;
    wait_idle("rand_drain", 60);
    check("rand_queues", cmd_q.size() + rsp_q.size(), 32'd0);
`ifdef HOST_CMD_BRIDGE_STATS_EN
    exp_wr = 16'(wr_seen);
    exp_rd = 16'(rd_seen);
`else
    exp_wr = 16'd0;
    exp_rd = 16'd0;
`endif
    check("rand_stats_wr", {16'd0, wr_count_o}, {16'd0, exp_wr});
    check("rand_stats_rd", {16'd0, rd_count_o}, {16'd0, exp_rd});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
